// File: rtl/micro_pkg.sv
// micro_pkg: opcodes, FSM state encoding, flag bit indices and idle ALU code for micro_seq_ctrl.
package micro_pkg;
  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_CMP   = 4'b0001;
  localparam logic [3:0] OP_JMP   = 4'b1000;
  localparam logic [3:0] OP_JZ    = 4'b1001;
  localparam logic [3:0] OP_JC    = 4'b1010;
  localparam logic [3:0] OP_JN    = 4'b1011;
  localparam logic [3:0] OP_NOP   = 4'b1100;
  localparam logic [3:0] OP_ILL0  = 4'b1101;
  localparam logic [3:0] OP_ILL1  = 4'b1110;
  localparam logic [3:0] OP_LAST  = 4'b1111;
  localparam logic [3:0] ALU_IDLE = 4'b1100;
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;
  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_WB, S_BRANCH, S_HALT} state_e;
  // ALU write ops and CMP share the EXEC path; everything with op[3]=1 except 1111 does not.
  function automatic logic is_exec(input logic [3:0] op);
    return !op[3] || op == OP_LAST;
  endfunction
  function automatic logic is_illegal(input logic [3:0] op);
    return op == OP_ILL0 || op == OP_ILL1;
  endfunction
endpackage

// File: rtl/micro_cond_eval.sv
// micro_cond_eval: branch-condition decode from opcode and latched {N,C,Z} flags.
module micro_cond_eval
  import micro_pkg::*;
(
  input  logic [3:0] op_i,
  input  logic [2:0] flags_i,
  output logic       taken_o
);
  assign taken_o = (op_i == OP_JMP) ||
                   (op_i == OP_JZ && flags_i[FLAG_Z]) ||
                   (op_i == OP_JC && flags_i[FLAG_C]) ||
                   (op_i == OP_JN && flags_i[FLAG_N]);
endmodule

// File: rtl/micro_seq_ctrl.sv
// micro_seq_ctrl: multi-cycle instruction sequencer for the MicroUAZ datapath (pc, flags, rf/alu control).
// Define MICRO_SEQ_ILLEGAL_TRAP_EN to trap illegal opcodes into a sticky HALT with err=1.
module micro_seq_ctrl
  import micro_pkg::*;
#(
  parameter int RA_W = 4,
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [15:0]     instr,
  input  logic [2:0]      flags_in,
  output logic [3:0]      alu_op,
  output logic [RA_W-1:0] rf_ra,
  output logic [RA_W-1:0] rf_rb,
  output logic [RA_W-1:0] rf_wa,
  output logic            rf_we,
  output logic [2:0]      flags_q,
  output logic [PC_W-1:0] pc,
  output logic            branch_taken,
  output logic            err
);
  state_e          state_q, state_d;
  logic [3:0]      op_q, alu_op_q;
  logic [PC_W-1:0] tgt_q, pc_q, pc_d;
  logic [RA_W-1:0] ra_q, rb_q, wa_q;
  logic [2:0]      flg_q;
  logic            we_q, bt_q, taken, adv;
`ifdef MICRO_SEQ_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  micro_cond_eval u_cond (.op_i(op_q), .flags_i(flg_q), .taken_o(taken));
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = instr_valid ? S_DECODE : S_IDLE;
      S_DECODE: state_d = is_exec(op_q) ? S_EXEC : (TRAP && is_illegal(op_q)) ? S_HALT : S_BRANCH;
      S_EXEC:   state_d = (op_q == OP_CMP) ? S_IDLE : S_WB;
      S_WB:     state_d = S_IDLE;
      S_BRANCH: state_d = S_IDLE;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end
  // bt_q already holds the decision taken in DECODE, so BRANCH uses it for the pc update.
  assign adv  = (state_q == S_WB) || (state_q == S_EXEC && op_q == OP_CMP) ||
                (state_q == S_BRANCH && !bt_q);
  assign pc_d = (state_q == S_BRANCH && bt_q) ? tgt_q : adv ? pc_q + PC_W'(1) : pc_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      tgt_q    <= '0;
      pc_q     <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      wa_q     <= '0;
      flg_q    <= '0;
      alu_op_q <= ALU_IDLE;
      we_q     <= 1'b0;
      bt_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (state_q == S_IDLE && instr_valid) begin
        op_q  <= instr[15:12];
        tgt_q <= instr[PC_W-1:0];
        ra_q  <= RA_W'(instr[7:4]);
        rb_q  <= RA_W'(instr[11:8]);
        wa_q  <= RA_W'(instr[11:8]);
      end
      if (state_q == S_EXEC) flg_q <= flags_in;
      alu_op_q <= (state_d == S_EXEC) ? op_q : ALU_IDLE;
      we_q     <= state_d == S_WB;
      bt_q     <= state_d == S_BRANCH && taken;
    end
  end
`ifdef MICRO_SEQ_ILLEGAL_TRAP_EN
  logic err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_q || state_d == S_HALT;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif
  assign instr_ready  = state_q == S_IDLE;
  assign alu_op       = alu_op_q;
  assign rf_ra        = ra_q;
  assign rf_rb        = rb_q;
  assign rf_wa        = wa_q;
  assign rf_we        = we_q;
  assign flags_q      = flg_q;
  assign pc           = pc_q;
  assign branch_taken = bt_q;
endmodule

// File: tb/tb_micro_seq_ctrl.sv
// tb_micro_seq_ctrl: trace-model bench for micro_seq_ctrl; each instruction expands to expected per-cycle outputs.
module tb_micro_seq_ctrl;
  localparam int RA_W = 4;
  localparam int PC_W = 8;
`ifdef MICRO_SEQ_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b1, instr_valid = 1'b0;
  logic [15:0] instr = '0;
  logic [2:0] flags_in = '0;
  logic instr_ready, rf_we, branch_taken, err;
  logic [3:0] alu_op;
  logic [RA_W-1:0] rf_ra, rf_rb, rf_wa;
  logic [2:0] flags_q;
  logic [PC_W-1:0] pc;
  micro_seq_ctrl #(.RA_W(RA_W), .PC_W(PC_W)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .flags_in(flags_in), .alu_op(alu_op), .rf_ra(rf_ra), .rf_rb(rf_rb),
    .rf_wa(rf_wa), .rf_we(rf_we), .flags_q(flags_q), .pc(pc),
    .branch_taken(branch_taken), .err(err)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic       rdy;
    logic [3:0] alu;
    logic [3:0] ra, rb, wa;
    logic       rf_chk;
    logic       we;
    logic [2:0] fl;
    logic [7:0] pc;
    logic       bt;
    logic       err;
  } exp_t;
  exp_t q[$];
  logic [7:0] m_pc;
  logic [2:0] m_fl;
  bit m_halt, active;
  int checks = 0, errors = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
    end
  endtask
  task automatic model_reset();
    q.delete();
    m_pc = 8'h00;
    m_fl = 3'b000;
    m_halt = 1'b0;
  endtask
  function automatic exp_t idle_exp();
    exp_t e;
    e.rdy = !m_halt; e.alu = 4'hC; e.ra = '0; e.rb = '0; e.wa = '0; e.rf_chk = 1'b0;
    e.we = 1'b0; e.fl = m_fl; e.pc = m_pc; e.bt = 1'b0; e.err = m_halt;
    return e;
  endfunction
  // Expands one instruction into the expected non-idle cycles and advances the architectural model.
  function automatic int predict(input logic [15:0] ins, input logic [2:0] fl);
    logic [3:0] op;
    exp_t e;
    bit tk;
    op = ins[15:12];
    e.rdy = 1'b0; e.alu = 4'hC; e.ra = ins[7:4]; e.rb = ins[11:8]; e.wa = ins[11:8];
    e.rf_chk = 1'b1; e.we = 1'b0; e.fl = m_fl; e.pc = m_pc; e.bt = 1'b0; e.err = 1'b0;
    q.push_back(e);
    if (op <= 4'd7 || op == 4'd15) begin
      e.alu = op;
      q.push_back(e);
      m_pc = m_pc + 8'd1;
      m_fl = fl;
      if (op == 4'd1) return 2;
      e.alu = 4'hC; e.we = 1'b1; e.fl = fl;
      q.push_back(e);
      return 3;
    end
    if (TRAP && (op == 4'd13 || op == 4'd14)) begin
      m_halt = 1'b1;
      return 1;
    end
    tk = op == 4'd8 || (op == 4'd9 && m_fl[0]) || (op == 4'd10 && m_fl[1]) || (op == 4'd11 && m_fl[2]);
    e.bt = tk;
    q.push_back(e);
    m_pc = tk ? ins[7:0] : m_pc + 8'd1;
    return 2;
  endfunction
  always @(negedge clk) begin
    if (active) begin
      exp_t e;
      if (q.size() != 0) e = q.pop_front();
      else e = idle_exp();
      chk("instr_ready", instr_ready, e.rdy);
      chk("alu_op", alu_op, e.alu);
      chk("rf_we", rf_we, e.we);
      chk("flags_q", flags_q, e.fl);
      chk("pc", pc, e.pc);
      chk("branch_taken", branch_taken, e.bt);
      chk("err", err, e.err);
      if (e.rf_chk) begin
        chk("rf_ra", rf_ra, e.ra);
        chk("rf_rb", rf_rb, e.rb);
        chk("rf_wa", rf_wa, e.wa);
      end
    end
  end
  function automatic logic [15:0] mk_alu(input logic [3:0] op, input logic [3:0] rx, input logic [3:0] ry);
    return {op, rx, ry, 4'h0};
  endfunction
  function automatic logic [15:0] mk_br(input logic [3:0] op, input logic [7:0] tgt);
    return {op, 4'h0, tgt};
  endfunction
  // flags_in carries the wanted value only during EXEC; its complement elsewhere exposes wrong-cycle latching.
  task automatic issue(input logic [15:0] ins, input logic [2:0] fl);
    int n;
    @(negedge clk); #1;
    n = predict(ins, fl);
    instr = ins; instr_valid = 1'b1; flags_in = ~fl;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      flags_in = (k == 1) ? fl : ~fl;
    end
  endtask
  task automatic do_reset();
    @(negedge clk); #1;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end
  initial begin
    #2 rst_n = 1'b0;
    model_reset();
    active = 1'b1;
    @(negedge clk); #1;
    chk("rst_instr_ready", instr_ready, 1'b1);
    chk("rst_alu_op", alu_op, 4'b1100);
    chk("rst_rf_ra", rf_ra, 4'h0);
    chk("rst_rf_rb", rf_rb, 4'h0);
    chk("rst_rf_wa", rf_wa, 4'h0);
    chk("rst_rf_we", rf_we, 1'b0);
    chk("rst_flags_q", flags_q, 3'b000);
    chk("rst_pc", pc, 8'h00);
    chk("rst_branch_taken", branch_taken, 1'b0);
    chk("rst_err", err, 1'b0);
    rst_n = 1'b1;
    issue(mk_alu(4'b0000, 4'd3, 4'd5), 3'b110);
    chk("add_pc", pc, 8'h01);
    chk("add_flags", flags_q, 3'b110);
    issue(mk_alu(4'b0001, 4'd1, 4'd2), 3'b001);
    chk("cmp_flags", flags_q, 3'b001);
    chk("cmp_pc", pc, 8'h02);
    issue(mk_br(4'b1001, 8'h40), 3'b110);
    chk("jz_taken_pc", pc, 8'h40);
    chk("jz_flags_kept", flags_q, 3'b001);
    issue(mk_alu(4'b0001, 4'd0, 4'd0), 3'b000);
    issue(mk_br(4'b1010, 8'h20), 3'b111);
    chk("jc_not_taken_pc", pc, 8'h42);
    issue(mk_br(4'b1000, 8'h20), 3'b111);
    chk("jmp_pc", pc, 8'h20);
    issue(mk_alu(4'b0001, 4'd4, 4'd6), 3'b100);
    issue(mk_br(4'b1011, 8'h30), 3'b011);
    chk("jn_taken_pc", pc, 8'h30);
    issue(mk_br(4'b1001, 8'h10), 3'b111);
    chk("jz_not_taken_pc", pc, 8'h31);
    issue(mk_alu(4'b0111, 4'd9, 4'd10), 3'b010);
    issue(mk_alu(4'b1111, 4'd15, 4'd0), 3'b011);
    chk("op15_flags", flags_q, 3'b011);
    issue(mk_br(4'b1010, 8'h50), 3'b100);
    issue(mk_br(4'b1000, 8'h50), 3'b100);
    chk("self_loop_pc", pc, 8'h50);
    issue(mk_br(4'b1000, 8'hFF), 3'b000);
    issue(mk_br(4'b1100, 8'h77), 3'b000);
    chk("pc_wrap", pc, 8'h00);
`ifndef MICRO_SEQ_ILLEGAL_TRAP_EN
    issue(mk_alu(4'b1101, 4'd2, 4'd3), 3'b111);
    chk("ill_nop_pc", pc, 8'h01);
    chk("ill_nop_err", err, 1'b0);
    issue(mk_alu(4'b1110, 4'd2, 4'd3), 3'b111);
    chk("ill2_nop_pc", pc, 8'h02);
`endif
    do_reset();
    @(negedge clk); #1;
    void'(predict(mk_alu(4'b0000, 4'd3, 4'd5), 3'b111));
    instr = mk_alu(4'b0000, 4'd3, 4'd5); instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    flags_in = 3'b111;
    @(negedge clk); #1;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk); #1;
    chk("abort_ready", instr_ready, 1'b1);
    chk("abort_pc", pc, 8'h00);
    chk("abort_we", rf_we, 1'b0);
    chk("abort_flags", flags_q, 3'b000);
`ifdef MICRO_SEQ_ILLEGAL_TRAP_EN
    issue(mk_br(4'b1100, 8'h00), 3'b000);
    issue(mk_alu(4'b1101, 4'd1, 4'd1), 3'b000);
    @(negedge clk); #1;
    instr = mk_br(4'b1100, 8'h00); instr_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1 instr_valid = 1'b0;
    chk("halt_err", err, 1'b1);
    chk("halt_ready", instr_ready, 1'b0);
    chk("halt_pc", pc, 8'h01);
    do_reset();
    @(negedge clk); #1;
    chk("post_halt_ready", instr_ready, 1'b1);
    chk("post_halt_err", err, 1'b0);
`endif
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/micro_seq_ctrl.md
# micro_seq_ctrl

Multi-cycle sequencer for the MicroUAZ 8-bit datapath. Accepts one 16-bit instruction per handshake, drives register-file read/write addresses and the 4-bit ALU operation code, and latches the Z/C/N flags produced by the flag indicator. It evaluates conditional branches against those latched flags and maintains the program counter. It sits between instruction memory and the ALU/flag-indicator/register-file datapath.

## Interface
- `N`, 8, datapath width; used only for bench checks, since data does not pass through this block.
- `RA_W`, 4, register address width.
- `PC_W`, 8, program counter width.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `instr_valid`  in  1  instruction word present.
- `instr_ready`  out  1  sequencer can accept an instruction.
- `instr`  in  16  [15:12] opcode, [11:8] rx (B/dest), [7:4] ry (A), [7:0] branch target.
- `flags_in`  in  3  {N,C,Z} from flag indicator, valid during EXEC.
- `alu_op`  out  4  operation code to ALU and flag indicator.
- `rf_ra`  out  RA_W  ry read address (operand A).
- `rf_rb`  out  RA_W  rx read address (operand B).
- `rf_wa`  out  RA_W  write address (= rx).
- `rf_we`  out  1  register-file write strobe, one cycle.
- `flags_q`  out  3  latched {N,C,Z}.
- `pc`  out  PC_W  program counter.
- `branch_taken`  out  1  one-cycle pulse on a taken branch.
- `err`  out  1  illegal opcode (see Configuration).

## Operation
- Opcode classes:
  - ALU write ops: 0000 ADD, 0010–0111, 1111.
  - CMP: 0001. Flags only, no write.
  - 1000 JMP, 1001 JZ, 1010 JC, 1011 JN.
  - 1100 NOP.
  - 1101 and 1110 are illegal.
- States: IDLE, DECODE, EXEC, WB, BRANCH, HALT.
- IDLE: `instr_ready`=1. On `instr_valid`&`instr_ready`, register `instr` and go to DECODE.
- DECODE: drive `rf_ra`/`rf_rb`/`rf_wa` from the registered instr. These hold until return to IDLE.
  - ALU/CMP → EXEC.
  - Branch/NOP → BRANCH.
  - Illegal → see Configuration.
- EXEC: `alu_op` = opcode. Latch `flags_q` ← `flags_in` at the end of the cycle.
  - CMP → IDLE with pc+1.
  - Others → WB.
- WB: `rf_we`=1 for exactly this cycle → IDLE, pc ← pc+1.
- BRANCH:
  - Condition: JMP always; JZ when `flags_q[0]`; JC when `flags_q[1]`; JN when `flags_q[2]`.
  - Taken: pc ← instr[7:0] and `branch_taken`=1 for this cycle.
  - Not taken or NOP: pc ← pc+1.
  - Next state is IDLE in all cases.
- Outside EXEC, `alu_op` = 4'b1100. The flag indicator holds its flags for that code.
- `flags_q` changes only at the end of EXEC. Branches and NOPs never modify it.
- pc arithmetic is modulo 2^PC_W: 8'hFF+1 → 8'h00.
- A branch target equal to the current pc is legal (self-loop).

## Timing
- Reset values: state IDLE, `instr_ready`=1, `alu_op`=4'b1100, `rf_ra`/`rf_rb`/`rf_wa`=0, `rf_we`=0, `flags_q`=3'b000, `pc`=0, `branch_taken`=0, `err`=0.
- Latency from accept edge:
  - ALU op: 4 cycles (DECODE, EXEC, WB, back to IDLE).
  - CMP: 3 cycles.
  - Branch/NOP: 3 cycles.
- Throughput is one instruction per 3–4 cycles. `instr_ready`=0 in every non-IDLE state.
- `instr_valid` while not ready is ignored. Upstream holds `instr`.
- Asserting `rst_n` mid-instruction aborts it: no `rf_we`, no pc update, all outputs go to reset values immediately.
- Outputs are registered, except `instr_ready`, which is decoded from state.

## Configuration
- `MICRO_SEQ_ILLEGAL_TRAP_EN` defined:
  - An illegal opcode in DECODE → HALT.
  - `err`=1 stays sticky and `instr_ready`=0.
  - Only reset exits HALT.
- Undefined:
  - An illegal opcode executes as a NOP (pc+1 via BRANCH).
  - `err` is tied 0 and HALT is unreachable.

## Structure
- Shared package `micro_pkg`:
  - opcode localparams;
  - state encoding;
  - flag bit indices Z=0, C=1, N=2;
  - the idle `alu_op` code 4'b1100.
- One sub-module, `micro_cond_eval`: combinational branch-condition decode from opcode and `flags_q` to a taken bit.
- FSM, pc and flag register live in the top module.

## Test plan
- After reset, check all outputs at their reset values. Send ADD rx=3 ry=5 → DECODE `rf_ra`=5 `rf_rb`=3; EXEC `alu_op`=0000; WB `rf_we`=1 `rf_wa`=3; pc=1, 4 cycles total.
- CMP with `flags_in`=3'b001 during EXEC → `flags_q`=001, no `rf_we`. Then JZ target 8'h40 → `branch_taken` pulse, pc=8'h40.
- `flags_q`=000, send JC target 8'h20 → not taken, pc+1, no pulse. Send JMP 8'h20 → pc=8'h20.
- pc=8'hFF, send NOP → pc=8'h00.
- Opcode 1101 with the macro defined → `err`=1, `instr_ready` stays 0, further valid is ignored. Without the macro → pc+1, `err`=0.
- Drop `rst_n` during EXEC of ADD → no `rf_we`, pc unchanged at 0, state IDLE after release.
